// File: rtl/aligner_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : aligner_pkg
//  Description : Shared types, default widths and tuser helper for the
//                multi-stream frame aligner.
//  Revision    : 1.0 - initial release
// ============================================================================
package aligner_pkg;

  // Aligner operating state
  typedef enum logic [1:0] {
    BYPASS = 2'd0,
    HUNT   = 2'd1,
    SYNCED = 2'd2
  } state_t;

  localparam int DEF_TIMEOUT_W = 20;
  localparam int DEF_CNT_W     = 8;
  localparam int MAX_CH        = 8;

  // True when the low n bits of tuser are all zero or all one, i.e. the
  // channels agree on whether this joint beat starts a frame.
  function automatic logic tuser_uniform(input logic [MAX_CH-1:0] tuser,
                                         input int n);
    logic all0;
    logic all1;
    all0 = 1'b1;
    all1 = 1'b1;
    for (int i = 0; i < MAX_CH; i++) begin
      if (i < n) begin
        all0 = all0 & ~tuser[i];
        all1 = all1 & tuser[i];
      end
    end
    return all0 | all1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/aligner_hunt_lane.sv
`default_nettype none
// ============================================================================
//  Module      : aligner_hunt_lane
//  Description : One channel of the aligner: holds the parked flag and muxes
//                the channel handshakes for bypass, hunt and synced modes.
//  Revision    : 1.0 - initial release
// ============================================================================
module aligner_hunt_lane (
  input  logic clk,
  input  logic resetn,
  input  logic is_hunt,
  input  logic is_synced,
  input  logic park_clr,
  input  logic ch_active,
  input  logic s_tvalid,
  input  logic s_tuser,
  input  logic m_tready,
  input  logic all_v,
  input  logic all_r,
  input  logic mismatch,
  output logic s_tready,
  output logic m_tvalid,
  output logic parked
);

  logic r_parked;

  // Park on the first SOF seen while hunting; the SOF beat itself is held.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_parked <= 1'b0;
    end else if (park_clr) begin
      r_parked <= 1'b0;
    end else if (is_hunt && ch_active && s_tvalid && s_tuser) begin
      r_parked <= 1'b1;
    end
  end

  // Handshake routing: pass-through, drain-to-SOF, or joint lockstep.
  always_comb begin
    s_tready = m_tready;
    m_tvalid = s_tvalid;
    if (is_synced) begin
      m_tvalid = all_v;
      s_tready = all_v & all_r & ~mismatch;
    end else if (is_hunt) begin
      m_tvalid = 1'b0;
      s_tready = r_parked ? 1'b0 : ~(s_tvalid & s_tuser);
    end
  end

  assign parked = r_parked;

endmodule
`default_nettype wire

// File: rtl/multi_stream_aligner.sv
`default_nettype none
// ============================================================================
//  Module      : multi_stream_aligner
//  Description : N-channel AXI-Stream SOF aligner. Bypasses when disabled,
//                otherwise parks each channel at its next SOF, releases all
//                channels in lockstep and re-hunts on loss or timeout.
//  Revision    : 1.0 - initial release
// ============================================================================
module multi_stream_aligner
  import aligner_pkg::*;
#(
  parameter int NUM_CH    = 2,
  parameter int TIMEOUT_W = DEF_TIMEOUT_W,
  parameter int CNT_W     = DEF_CNT_W
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              enable,
  input  logic [NUM_CH-1:0] ch_active,
  input  logic [NUM_CH-1:0] s_tvalid,
  input  logic [NUM_CH-1:0] s_tuser,
  output logic [NUM_CH-1:0] s_tready,
  output logic [NUM_CH-1:0] m_tvalid,
  input  logic [NUM_CH-1:0] m_tready,
  output logic              locked,
  output logic              sync_err,
  output logic [CNT_W-1:0]  resync_cnt
);

  // Timer value on whose edge the hunt window of 2^TIMEOUT_W-1 cycles closes.
  localparam logic [TIMEOUT_W-1:0] c_timer_last = {{(TIMEOUT_W-1){1'b1}}, 1'b0};
  localparam logic [TIMEOUT_W-1:0] c_timer_one  = {{(TIMEOUT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0]     c_cnt_one    = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t                r_state;
  state_t                w_state_next;
  logic [TIMEOUT_W-1:0]  r_timer;
  logic [TIMEOUT_W-1:0]  w_timer_next;
  logic                  r_locked;
  logic                  r_sync_err;
  logic [CNT_W-1:0]      r_resync_cnt;
  logic                  w_err;
  logic                  w_cnt_inc;
  logic                  w_park_clr;
  logic [NUM_CH-1:0]     w_parked;
  logic [MAX_CH-1:0]     w_tuser_ext;
  logic                  w_all_v;
  logic                  w_all_r;
  logic                  w_mismatch;
  logic                  w_loss;
  logic                  w_is_hunt;
  logic                  w_is_synced;

  assign w_all_v     = &s_tvalid;
  assign w_all_r     = &m_tready;
  assign w_is_hunt   = (r_state == HUNT);
  assign w_is_synced = (r_state == SYNCED);

  // Zero-extend tuser so the package helper can check any channel count.
  always_comb begin
    w_tuser_ext               = '0;
    w_tuser_ext[NUM_CH-1:0]   = s_tuser;
  end

  assign w_mismatch = w_is_synced & w_all_v & w_all_r &
                      ~tuser_uniform(w_tuser_ext, NUM_CH);
  assign w_loss     = ~(&ch_active) | w_mismatch;

  // Next-state logic: enable low dominates, then timeout before park-complete.
  always_comb begin
    w_state_next = r_state;
    w_timer_next = r_timer;
    w_err        = 1'b0;
    w_cnt_inc    = 1'b0;
    w_park_clr   = 1'b0;
    if (!enable) begin
      w_state_next = BYPASS;
      w_timer_next = '0;
      w_park_clr   = 1'b1;
    end else begin
      case (r_state)
        BYPASS: begin
          w_state_next = HUNT;
          w_timer_next = '0;
          w_park_clr   = 1'b1;
        end
        HUNT: begin
          if (r_timer == c_timer_last) begin
            w_timer_next = '0;
            w_park_clr   = 1'b1;
            w_err        = 1'b1;
          end else if (&w_parked) begin
            w_state_next = SYNCED;
            w_timer_next = '0;
            w_cnt_inc    = 1'b1;
          end else begin
            w_timer_next = r_timer + c_timer_one;
          end
        end
        SYNCED: begin
          if (w_loss) begin
            w_state_next = HUNT;
            w_timer_next = '0;
            w_park_clr   = 1'b1;
            w_err        = 1'b1;
          end
        end
        default: begin
          w_state_next = BYPASS;
          w_timer_next = '0;
          w_park_clr   = 1'b1;
        end
      endcase
    end
  end

  // State, timer and registered status outputs.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state      <= BYPASS;
      r_timer      <= '0;
      r_locked     <= 1'b0;
      r_sync_err   <= 1'b0;
      r_resync_cnt <= '0;
    end else begin
      r_state    <= w_state_next;
      r_timer    <= w_timer_next;
      r_locked   <= (w_state_next == SYNCED);
      r_sync_err <= w_err;
      if (w_cnt_inc && (r_resync_cnt != '1)) begin
        r_resync_cnt <= r_resync_cnt + c_cnt_one;
      end
    end
  end

  generate
    for (genvar i = 0; i < NUM_CH; i++) begin : g_lane
      aligner_hunt_lane u_lane (
        .clk       (clk),
        .resetn    (resetn),
        .is_hunt   (w_is_hunt),
        .is_synced (w_is_synced),
        .park_clr  (w_park_clr),
        .ch_active (ch_active[i]),
        .s_tvalid  (s_tvalid[i]),
        .s_tuser   (s_tuser[i]),
        .m_tready  (m_tready[i]),
        .all_v     (w_all_v),
        .all_r     (w_all_r),
        .mismatch  (w_mismatch),
        .s_tready  (s_tready[i]),
        .m_tvalid  (m_tvalid[i]),
        .parked    (w_parked[i])
      );
    end
  endgenerate

  assign locked     = r_locked;
  assign sync_err   = r_sync_err;
  assign resync_cnt = r_resync_cnt;

endmodule
`default_nettype wire

// File: tb/tb_multi_stream_aligner.sv
`default_nettype none
// ============================================================================
//  Module      : tb_multi_stream_aligner
//  Description : Self-checking bench for multi_stream_aligner with a
//                behavioural model of bypass / hunt / synced rules.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_multi_stream_aligner;

  localparam int NCH        = 3;
  localparam int TW         = 6;
  localparam int CW         = 8;
  localparam int HUNT_LIMIT = (1 << TW) - 1;
  localparam int CNT_MAX    = (1 << CW) - 1;
  localparam int MB = 0, MH = 1, MS = 2;

  logic           clk = 1'b0;
  logic           resetn;
  logic           enable;
  logic [NCH-1:0] ch_active, s_tvalid, s_tuser, s_tready, m_tvalid, m_tready;
  logic           locked, sync_err;
  logic [CW-1:0]  resync_cnt;

  always #5 clk = ~clk;

  multi_stream_aligner #(.NUM_CH(NCH), .TIMEOUT_W(TW), .CNT_W(CW)) dut (
    .clk        (clk),
    .resetn     (resetn),
    .enable     (enable),
    .ch_active  (ch_active),
    .s_tvalid   (s_tvalid),
    .s_tuser    (s_tuser),
    .s_tready   (s_tready),
    .m_tvalid   (m_tvalid),
    .m_tready   (m_tready),
    .locked     (locked),
    .sync_err   (sync_err),
    .resync_cnt (resync_cnt)
  );

  int n_chk = 0, n_pass = 0, n_fail = 0;

  // Behavioural model state
  int  m_mode;
  bit  m_parked[NCH];
  int  m_age;            // cycles spent hunting since the last clear
  bit  m_locked, m_err;
  int  m_cnt;

  // Last sampled DUT values (taken mid-cycle in step)
  logic [NCH-1:0] last_rdy, last_vld;
  logic           last_locked, last_err;
  int             xfer[NCH];

  int sof_cyc[NCH] = '{10, 40, 25};
  int err_a, err_b, n_err;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed 'h%0h required 'h%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_mode = MB;
    foreach (m_parked[i]) m_parked[i] = 1'b0;
    m_age = 0; m_locked = 1'b0; m_err = 1'b0; m_cnt = 0;
  endtask

  function automatic bit mixed_joint();
    bit joint;
    joint = (s_tvalid == {NCH{1'b1}}) && (m_tready == {NCH{1'b1}});
    return joint && (s_tuser != '0) && (s_tuser != {NCH{1'b1}});
  endfunction

  task automatic expected(output logic [NCH-1:0] rdy, output logic [NCH-1:0] vld);
    bit allv, allr;
    allv = (s_tvalid == {NCH{1'b1}});
    allr = (m_tready == {NCH{1'b1}});
    rdy = '0; vld = '0;
    for (int i = 0; i < NCH; i++) begin
      case (m_mode)
        MB: begin rdy[i] = m_tready[i]; vld[i] = s_tvalid[i]; end
        MH: begin rdy[i] = m_parked[i] ? 1'b0 : !(s_tvalid[i] && s_tuser[i]); vld[i] = 1'b0; end
        default: begin rdy[i] = allv && allr && !mixed_joint(); vld[i] = allv; end
      endcase
    end
  endtask

  task automatic clear_parked();
    foreach (m_parked[i]) m_parked[i] = 1'b0;
  endtask

  task automatic model_edge();
    bit err, all_parked;
    err = 1'b0;
    if (!resetn) begin model_reset(); return; end
    all_parked = 1'b1;
    foreach (m_parked[i]) all_parked &= m_parked[i];
    if (!enable) begin
      m_mode = MB; clear_parked(); m_age = 0;
    end else if (m_mode == MB) begin
      m_mode = MH; clear_parked(); m_age = 0;
    end else if (m_mode == MH) begin
      if (m_age + 1 == HUNT_LIMIT) begin
        err = 1'b1; clear_parked(); m_age = 0;
      end else if (all_parked) begin
        m_mode = MS; m_age = 0;
        if (m_cnt < CNT_MAX) m_cnt++;
      end else begin
        m_age++;
        for (int i = 0; i < NCH; i++)
          if (ch_active[i] && s_tvalid[i] && s_tuser[i]) m_parked[i] = 1'b1;
      end
    end else begin
      if ((ch_active != {NCH{1'b1}}) || mixed_joint()) begin
        err = 1'b1; m_mode = MH; clear_parked(); m_age = 0;
      end
    end
    m_err    = err;
    m_locked = (m_mode == MS);
  endtask

  task automatic check_all();
    logic [NCH-1:0] rdy, vld;
    expected(rdy, vld);
    chk("s_tready", 32'(s_tready), 32'(rdy));
    chk("m_tvalid", 32'(m_tvalid), 32'(vld));
    chk("locked", 32'(locked), 32'(m_locked));
    chk("sync_err", 32'(sync_err), 32'(m_err));
    chk("resync_cnt", 32'(resync_cnt), 32'(m_cnt));
  endtask

  // One clock cycle: compare mid-cycle, then advance model on the edge.
  task automatic step();
    @(negedge clk);
    check_all();
    last_rdy = s_tready; last_vld = m_tvalid;
    last_locked = locked; last_err = sync_err;
    for (int i = 0; i < NCH; i++) if (s_tvalid[i] && s_tready[i]) xfer[i]++;
    @(posedge clk);
    model_edge();
    #1;
  endtask

  initial begin
    resetn = 1'b0; enable = 1'b0; ch_active = '1;
    s_tvalid = '0; s_tuser = '0; m_tready = '0;
    model_reset();
    foreach (xfer[i]) xfer[i] = 0;
    repeat (3) step();
    chk("rst_locked", 32'(locked), 32'd0);
    chk("rst_err", 32'(sync_err), 32'd0);
    chk("rst_cnt", 32'(resync_cnt), 32'd0);
    resetn = 1'b1;

    // Bypass with random handshakes
    for (int c = 0; c < 40; c++) begin
      s_tvalid = NCH'($urandom); s_tuser = NCH'($urandom);
      m_tready = NCH'($urandom); ch_active = NCH'($urandom);
      step();
      chk("byp_locked", 32'(last_locked), 32'd0);
    end

    // Lock: SOFs at hunt cycles 10 (ch0), 25 (ch2), 40 (ch1)
    ch_active = '1; m_tready = '1; s_tvalid = '0; s_tuser = '0; enable = 1'b1;
    step();
    for (int c = 0; c <= 42; c++) begin
      for (int i = 0; i < NCH; i++) begin
        if (c >= sof_cyc[i]) begin s_tvalid[i] = 1'b1; s_tuser[i] = 1'b1; end
        else begin s_tvalid[i] = 1'($urandom); s_tuser[i] = 1'b0; end
      end
      step();
      if (c == 12) chk("ch0_stall", 32'(last_rdy[0]), 32'd0);
      if (c == 30) chk("ch2_stall", 32'(last_rdy[2]), 32'd0);
      if (c == 41) chk("lock_c41", 32'(last_locked), 32'd0);
      if (c == 42) begin
        chk("lock_c42", 32'(last_locked), 32'd1);
        chk("sof_xfer_rdy", 32'(last_rdy), 32'h7);
        chk("sof_xfer_vld", 32'(last_vld), 32'h7);
      end
    end
    chk("cnt_1", 32'(resync_cnt), 32'd1);

    // Lockstep backpressure until 640 beats per channel
    foreach (xfer[i]) xfer[i] = 0;
    for (int c = 0; c < 4000 && xfer[0] < 640; c++) begin
      for (int i = 0; i < NCH; i++) begin
        s_tvalid[i] = ($urandom_range(7) != 0);
        m_tready[i] = ($urandom_range(3) != 0);
      end
      s_tuser = ($urandom_range(15) == 0) ? '1 : '0;
      if (c >= 100 && c < 105) m_tready[1] = 1'b0;
      step();
      if (c >= 100 && c < 105) chk("bp_stall", 32'(last_rdy), 32'd0);
    end
    for (int i = 0; i < NCH; i++) chk("bp_beats", 32'(xfer[i]), 32'd640);
    chk("bp_locked", 32'(locked), 32'd1);

    // Mismatched SOF on a joint beat
    s_tvalid = '1; m_tready = '1; s_tuser = 3'b001;
    step();
    chk("mm_rdy", 32'(last_rdy), 32'd0);
    chk("mm_vld", 32'(last_vld), 32'h7);
    s_tuser = '1;
    step();
    chk("mm_err", 32'(last_err), 32'd1);
    chk("mm_locked", 32'(last_locked), 32'd0);
    repeat (3) step();
    chk("relock", 32'(locked), 32'd1);
    chk("cnt_2", 32'(resync_cnt), 32'd2);

    // ch_active[0] drop in SYNCED, then timeout with ch1 never sending SOF
    s_tuser = '0; ch_active = 3'b110;
    step();
    ch_active = '1;
    s_tvalid = '1; s_tuser = 3'b101;
    step();
    chk("act_err", 32'(last_err), 32'd1);
    chk("act_locked", 32'(last_locked), 32'd0);
    err_a = -1; err_b = -1; n_err = 0;
    for (int k = 1; k <= 130; k++) begin
      s_tvalid = NCH'($urandom) | 3'b101;
      s_tuser = 3'b101;
      step();
      if (last_err) begin
        n_err++;
        if (err_a < 0) err_a = k; else if (err_b < 0) err_b = k;
      end
    end
    chk("to_first", 32'(err_a), 32'd63);
    chk("to_second", 32'(err_b), 32'd126);
    chk("to_count", 32'(n_err), 32'd2);

    // Enable drop in SYNCED together with a loss condition
    s_tvalid = '1; s_tuser = '1;
    repeat (4) step();
    chk("en_pre_lock", 32'(locked), 32'd1);
    enable = 1'b0; ch_active = 3'b000;
    step();
    ch_active = '1; s_tvalid = 3'b010; m_tready = 3'b101;
    step();
    chk("en_no_err", 32'(last_err), 32'd0);
    chk("en_unlock", 32'(last_locked), 32'd0);
    chk("en_byp_rdy", 32'(last_rdy), 32'h5);

    // Asynchronous reset mid-HUNT
    enable = 1'b1;
    repeat (6) begin
      s_tvalid = NCH'($urandom); s_tuser = 3'b001; m_tready = NCH'($urandom);
      step();
    end
    resetn = 1'b0;
    #1;
    chk("arst_locked", 32'(locked), 32'd0);
    chk("arst_err", 32'(sync_err), 32'd0);
    chk("arst_cnt", 32'(resync_cnt), 32'd0);
    model_reset();
    repeat (2) step();
    resetn = 1'b1;
    repeat (4) step();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
